// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding
// and frame geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Collects bytes into big-endian words; the first byte of a word lands in the
// most significant lane. word_ready pulses the cycle after the last lane.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        lane_last,
  output logic        word_ready,
  output logic [31:0] word
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int SHW    = 8 * (BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane;
  logic [SHW-1:0]    shift;

  assign lane_last = (lane == LANE_W'(BYTES_PER_WORD - 1));

  // word only updates on completion, so it holds the last written value.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lane       <= '0;
      shift      <= '0;
      word_ready <= 1'b0;
      word       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      word_ready <= byte_en && lane_last;
      if (clear) begin
        lane <= '0;
      end else if (byte_en) begin
        if (lane_last) word <= {shift, byte_in};
        else           shift <= {shift[SHW-9:0], byte_in};
        lane <= lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: parses count header, packs words, writes
// instruction memory, verifies XOR checksum and holds the CPU throughout.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int CNT_W = 8 * HDR_BYTES;
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  state_t state, state_nx;

  logic [7:0]       cnt_hi;
  logic [7:0]       csum;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] index;
  logic [CNT_W-1:0] hdr_count;
  logic             accept;
  logic             data_accept;
  logic             word_done;
  logic             lane_last;

  assign accept      = in_valid && in_ready;
  assign data_accept = accept && (state == S_DATA);
  assign word_done   = data_accept && lane_last;
  assign hdr_count   = {cnt_hi, in_data};

  imem_word_packer u_packer (
    .CLK        (CLK),
    .RESET      (RESET),
    .clear      (state == S_IDLE),
    .byte_en    (data_accept),
    .byte_in    (in_data),
    .lane_last  (lane_last),
    .word_ready (wr_en),
    .word       (wr_data)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = (state != S_IDLE);
    cpu_hold  = (state != S_IDLE);
    load_done = (state == S_DONE);
    load_err  = (state == S_ERR);
    case (state)
      S_IDLE: if (start) state_nx = S_HDR_HI;
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = (hdr_count == '0 || hdr_count > CNT_W'(MAX_WORDS)) ? S_ERR : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && lane_last && index == count - 1'b1) state_nx = S_CSUM;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Address is captured with the completing byte so it lines up with wr_en.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_hi  <= '0;
      count   <= '0;
      index   <= '0;
      csum    <= '0;
      wr_addr <= '0;
    end else begin
      if (state == S_IDLE) begin
        index <= '0;
        csum  <= '0;
      end
      if (accept && state == S_HDR_HI) cnt_hi <= in_data;
      if (accept && state == S_HDR_LO) count  <= hdr_count;
      if (data_accept) csum <= csum ^ in_data;
      if (word_done) begin
        wr_addr <= BASE_A + {index[ADDR_WIDTH-3:0], 2'b00};
        index   <= index + 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the CPU's read-only instruction memory.
- Receives a framed program image over a valid/ready byte interface and assembles big-endian 32-bit words (first byte received = instruction bits [31:24]).
- Writes each word into instruction memory through a single-cycle write port.
- Holds the CPU (cpu_hold) for the whole load, then reports success or error.

Parameters:
- ADDR_WIDTH, 10, byte-address width of instruction memory (1024 bytes).
- BASE_ADDR, 0, byte address of the first word written; must be 4-aligned.
- MAX_WORDS, 256, largest accepted word count; BASE_ADDR + 4*MAX_WORDS must not exceed 2^ADDR_WIDTH.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored unless idle.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle. A byte transfers when in_valid && in_ready at the clock edge.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_WIDTH  byte address of the word being written.
- wr_data  out  32  word being written, big-endian assembled.
- cpu_hold  out  1  CPU held in reset while high.
- busy  out  1  state is not IDLE.
- load_done  out  1  one-cycle pulse: load finished and checksum matched.
- load_err  out  1  one-cycle pulse: bad count or checksum mismatch.

Behaviour:
- Frame format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4*N data bytes, then 1 checksum byte. The checksum is the XOR of all data bytes; header bytes are excluded.
- Reset (asynchronous, any time, including mid-load):
  - state=IDLE.
  - All outputs 0: in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, load_done, load_err.
  - Counters and checksum accumulator cleared.
  - Words already written are not rolled back.
- States:
  - IDLE -> HDR_HI on start. cpu_hold rises in the same edge.
  - HDR_HI -> HDR_LO on byte accept.
  - HDR_LO -> on byte accept:
    - N==0 or N>MAX_WORDS: -> ERR.
    - Otherwise: -> DATA.
  - DATA -> CSUM when the final byte of word N-1 is accepted.
  - CSUM -> on byte accept:
    - Byte == accumulator: -> DONE.
    - Otherwise: -> ERR.
  - DONE -> IDLE and ERR -> IDLE after one cycle.
- in_ready: 1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in IDLE, DONE and ERR. There is no backpressure from the write port.
- Byte lane counter (2 bits), 0 to 3 within each word:
  - Lane 0 byte goes to word bits [31:24]; lane 3 byte goes to bits [7:0].
  - Lane wraps 3 -> 0.
  - The word index increments on lane 3 accept.
- Write timing: in the cycle after the lane-3 accept:
  - wr_en=1 for exactly one cycle.
  - wr_data = assembled word.
  - wr_addr = BASE_ADDR + 4*index, truncated to ADDR_WIDTH bits.
- Back-to-back writes are possible: with in_valid held high, a new word completes every 4 cycles.
- Deasserted in_valid stalls: no state, lane or checksum change while in_valid is low.
- Write of the last word: its wr_en occurs in the first CSUM cycle, concurrent with in_ready=1. If the checksum byte arrives in that same cycle, both events happen normally.
- Completion:
  - load_done or load_err is high in the DONE or ERR cycle.
  - cpu_hold and busy fall on the edge leaving DONE or ERR.
  - load_done and load_err are never both high.
- start while busy: ignored, no effect.
- start and RESET together: reset wins.
- wr_addr and wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package (constants only):
  - State encoding: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
  - Header length (2) and bytes-per-word (4).
- One natural sub-module: imem_word_packer. It contains the lane counter, the shift-in of 4 bytes into a 32-bit word, and the word_ready pulse.
- The FSM, index counter, checksum accumulator and address generation stay in the top level.

Test Plan:
- Good load, BASE_ADDR=0, continuous in_valid:
  - Stream 00 02 | 00 01 10 20 | 00 64 28 24 | 59.
  - Expect writes 0x00011020 at address 0 and 0x00642824 at address 4.
  - Expect load_done pulse, no load_err, cpu_hold high from the start edge until the cycle after DONE.
- Bad checksum: same stream with final byte 58.
  - Both words are still written.
  - load_err pulses, load_done stays 0.
- Count 0 (00 00): load_err pulses after the 2nd byte, no wr_en, in_ready=0 afterwards. Repeat with 01 01 (257 > MAX_WORDS): same response.
- Backpressure: good-load stream with in_valid low for 3 cycles between every byte.
  - Write data, addresses and load_done are identical to the continuous case.
  - Exactly one wr_en per word.
- Reset mid-load: assert RESET after the 6th byte of the good stream.
  - All outputs go to 0 immediately (asynchronous).
  - A subsequent start plus full good stream succeeds.
  - start pulsed during a load is ignored (no restart, same writes).
